// File: rtl/gh_pkg.sv
// gh_pkg: shared types and constants for the gameplay datapath.
//   seq_state_t : song sequencer FSM states
//   NOTE_W      : lane pattern width (5 lanes)
//   POS_W       : song position width
//   ROM_DEPTH   : song memory depth
//   SONG_INIT   : song chart contents, entry i at [i*NOTE_W +: NOTE_W]
package gh_pkg;

    localparam int unsigned NOTE_W    = 5;
    localparam int unsigned POS_W     = 7;
    localparam int unsigned ROM_DEPTH = 128;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StPlay,
        StPaused,
        StDone
    } seq_state_t;

    // Song chart: steps 0..3 hold the opening pattern, the rest are rests.
    localparam logic [ROM_DEPTH*NOTE_W-1:0] SONG_INIT = {
        {((ROM_DEPTH - 4) * NOTE_W){1'b0}},
        5'b00110, 5'b10000, 5'b00000, 5'b00001
    };

endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read song memory, ROM_DEPTH x NOTE_W, one cycle latency.
//   clk  : system clock
//   addr : step index to read
//   data : lane pattern at addr, valid the cycle after addr is presented
module song_rom
    import gh_pkg::*;
#(
    parameter logic [ROM_DEPTH*NOTE_W-1:0] INIT = SONG_INIT
) (
    input  logic              clk,
    input  logic [POS_W-1:0]  addr,
    output logic [NOTE_W-1:0] data
);

    logic [NOTE_W-1:0] rom [ROM_DEPTH];

    for (genvar i = 0; i < int'(ROM_DEPTH); i++) begin : g_rom
        assign rom[i] = INIT[i*NOTE_W +: NOTE_W];
    end

    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps through the song chart at a fixed tempo, presents the
// expected note, opens a hit window per note and judges hit or miss.
//   clk, clear  : clock, asynchronous active-high reset
//   start       : begin playback from step 0 (honoured in idle/done only)
//   pause       : freeze playback while high
//   match       : buttons equal the expected note
//   note        : expected lane pattern for the current step (0 = rest)
//   song_pos    : current step index
//   window_open : hit window active for a non-rest, unjudged note
//   hit, miss   : one-cycle judgement pulses
//   busy, done  : playback in progress / song finished
// Build option: define SONG_LOOP_EN to wrap from the last step back to step 0
// forever instead of finishing.
module song_sequencer
    import gh_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 12_500_000,
    parameter int unsigned WINDOW_TICKS   = 3_125_000,
    parameter int unsigned SONG_LEN       = 128
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              pause,
    input  logic              match,
    output logic [NOTE_W-1:0] note,
    output logic [POS_W-1:0]  song_pos,
    output logic              window_open,
    output logic              hit,
    output logic              miss,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_STEP);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [TICK_W-1:0] TICK_WIN  = TICK_W'(WINDOW_TICKS);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SONG_LEN - 1);

    seq_state_t        state_q, state_d;
    logic              prime_q, prime_d;   // set in the second PRIME cycle
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              judged_q, judged_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic [POS_W-1:0]  rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic              win;

    song_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign win = (state_q == StPlay) && (tick_q < TICK_WIN) && (note_q != '0) && !judged_q;

    always_comb begin
        state_d  = state_q;
        prime_d  = prime_q;
        tick_d   = tick_q;
        pos_d    = pos_q;
        note_d   = note_q;
        judged_d = judged_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        // Prefetch the next step so its word is ready at the step boundary.
        rom_addr = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StPrime;
                    prime_d = 1'b0;
                end
            end
            StPrime: begin
                rom_addr = '0;
                if (!prime_q) begin
                    prime_d = 1'b1;
                end else begin
                    prime_d  = 1'b0;
                    note_d   = rom_data;
                    pos_d    = '0;
                    tick_d   = '0;
                    judged_d = 1'b0;
                    state_d  = StPlay;
                end
            end
            StPlay: begin
                // The cycle that samples pause still counts; the frozen cycles
                // are the ones spent in StPaused, so a step stretches by exactly
                // the number of cycles pause was high.
                if (pause) begin
                    state_d = StPaused;
                end
                if (win && match) begin
                    judged_d = 1'b1;
                    hit_d    = 1'b1;
                end else if (tick_q == TICK_WIN && note_q != '0 && !judged_q) begin
                    judged_d = 1'b1;
                    miss_d   = 1'b1;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d   = '0;
                    judged_d = 1'b0;
`ifdef SONG_LOOP_EN
                    pos_d  = rom_addr;
                    note_d = rom_data;
`else
                    if (pos_q == POS_LAST) begin
                        state_d = StDone;
                    end else begin
                        pos_d  = rom_addr;
                        note_d = rom_data;
                    end
`endif
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            StPaused: begin
                if (!pause) begin
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= StIdle;
            prime_q  <= 1'b0;
            tick_q   <= '0;
            pos_q    <= '0;
            note_q   <= '0;
            judged_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prime_q  <= prime_d;
            tick_q   <= tick_d;
            pos_q    <= pos_d;
            note_q   <= note_d;
            judged_q <= judged_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign note        = note_q;
    assign song_pos    = pos_q;
    assign window_open = win;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign busy        = (state_q == StPrime) || (state_q == StPlay) || (state_q == StPaused);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench for song_sequencer with a 4-step chart,
// 8 ticks per step and a 3-tick hit window. Expected hit/miss pulses are queued
// with their due cycle as stimulus is applied and compared every cycle.
module tb_song_sequencer;

    localparam int TPS = 8;
    localparam int WIN = 3;
    localparam int LEN = 4;

    typedef struct {
        int   cyc;
        logic is_hit;
    } evt_t;

    logic       clk;
    logic       clear;
    logic       start;
    logic       pause;
    logic       match;
    logic [4:0] note;
    logic [6:0] song_pos;
    logic       window_open;
    logic       hit;
    logic       miss;
    logic       busy;
    logic       done;

    int         cyc;
    int         n_vec;
    int         n_err;
    evt_t       exp_q[$];
    int         match_rs[$];
    int         pause_r;
    int         pause_len;
    int         done_r;
    logic [4:0] song_tb [LEN];

    song_sequencer #(
        .TICKS_PER_STEP (TPS),
        .WINDOW_TICKS   (WIN),
        .SONG_LEN       (LEN)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .pause       (pause),
        .match       (match),
        .note        (note),
        .song_pos    (song_pos),
        .window_open (window_open),
        .hit         (hit),
        .miss        (miss),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock and compare the judgement pulses against the scoreboard.
    task automatic next_cycle();
        logic exp_hit;
        logic exp_miss;
        @(posedge clk);
        #1;
        cyc++;
        exp_hit  = 1'b0;
        exp_miss = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_hit  = exp_q[0].is_hit;
            exp_miss = !exp_q[0].is_hit;
            void'(exp_q.pop_front());
        end
        check("pulse", 32'({hit, miss}), 32'({exp_hit, exp_miss}));
    endtask

    task automatic check_reset();
        check("rst_note", 32'(note), 32'(0));
        check("rst_pos", 32'(song_pos), 32'(0));
        check("rst_window", 32'(window_open), 32'(0));
        check("rst_hit", 32'(hit), 32'(0));
        check("rst_miss", 32'(miss), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
    endtask

    // Asynchronous clear in the middle of a cycle, checked before any edge.
    task automatic do_clear();
        #2;
        clear = 1'b1;
        #1;
        check_reset();
        next_cycle();
        next_cycle();
        clear = 1'b0;
        next_cycle();
    endtask

    // Pulse start at cycle N; returns in cycle N+3 (first PLAY cycle).
    task automatic start_song();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("busy_n1", 32'(busy), 32'(1));
        check("done_n1", 32'(done), 32'(0));
        next_cycle();
        next_cycle();
        check("note_n3", 32'(note), 32'(5'b00001));
        check("pos_n3", 32'(song_pos), 32'(0));
        check("window_n3", 32'(window_open), 32'(1));
    endtask

    function automatic bit is_match(int r);
        foreach (match_rs[i]) begin
            if (match_rs[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Play n cycles from PLAY entry against a cycle model of the song.
    task automatic run_play(input int n, output int first_done);
        int   m_tick;
        int   m_step;
        logic m_judged;
        logic m_paused;
        logic m_done;
        logic m_win;
        logic p_in;
        logic m_in;
        m_tick     = 0;
        m_step     = 0;
        m_judged   = 1'b0;
        m_paused   = 1'b0;
        m_done     = 1'b0;
        first_done = -1;
        for (int r = 0; r < n; r++) begin
            m_win = !m_done && !m_paused && m_tick < WIN && song_tb[m_step] != 0 && !m_judged;
            check("pos", 32'(song_pos), 32'(m_step));
            check("note", 32'(note), 32'(song_tb[m_step]));
            check("window", 32'(window_open), 32'(m_win));
            check("busy", 32'(busy), 32'(!m_done));
            check("done", 32'(done), 32'(m_done));
            if (done && first_done < 0) first_done = r;

            m_in  = is_match(r);
            p_in  = (r >= pause_r) && (r < pause_r + pause_len);
            match = m_in;
            pause = p_in;

            if (!m_done) begin
                if (!m_paused) begin
                    if (m_in && m_win) begin
                        m_judged = 1'b1;
                        exp_q.push_back('{cyc: cyc + 1, is_hit: 1'b1});
                    end else if (m_tick == WIN && song_tb[m_step] != 0 && !m_judged) begin
                        m_judged = 1'b1;
                        exp_q.push_back('{cyc: cyc + 1, is_hit: 1'b0});
                    end
                    if (m_tick == TPS - 1) begin
                        m_tick   = 0;
                        m_judged = 1'b0;
                        if (m_step == LEN - 1) begin
`ifdef SONG_LOOP_EN
                            m_step = 0;
`else
                            m_done = 1'b1;
`endif
                        end else begin
                            m_step++;
                        end
                    end else begin
                        m_tick++;
                    end
                    if (p_in && !m_done) m_paused = 1'b1;
                end else if (!p_in) begin
                    m_paused = 1'b0;
                end
            end
            next_cycle();
        end
        match = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        cyc        = 0;
        n_vec      = 0;
        n_err      = 0;
        clear      = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        match      = 1'b0;
        song_tb[0] = 5'b00001;
        song_tb[1] = 5'b00000;
        song_tb[2] = 5'b10000;
        song_tb[3] = 5'b00110;
        #3;
        check_reset();
        next_cycle();
        next_cycle();
        clear = 1'b0;
        next_cycle();

        // Run A: double match in step 0, match on rest, pause mid-window of step 3.
        match_rs  = '{1, 2, 9, 26, 28, 31};
        pause_r   = 25;
        pause_len = 5;
        start_song();
        run_play(38, done_r);
`ifdef SONG_LOOP_EN
        check("loop_no_done_a", 32'(done_r), 32'(-1));
        do_clear();
`else
        check("done_lat_pause", 32'(done_r), 32'(37));
`endif

        // Run B: match on the last window tick, full song (three passes when looping).
        match_rs  = '{2};
        pause_r   = -100;
        pause_len = 0;
        start_song();
`ifdef SONG_LOOP_EN
        run_play(100, done_r);
        check("loop_no_done_b", 32'(done_r), 32'(-1));
        do_clear();
`else
        run_play(34, done_r);
        check("done_lat", 32'(done_r), 32'(32));
`endif

        // Run C: clear mid step 2, then replay from step 0.
        match_rs = '{};
        start_song();
        run_play(18, done_r);
        check("pos_before_clear", 32'(song_pos), 32'(2));
        do_clear();
        start_song();
        run_play(12, done_r);

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays a stored note chart in real time and drives the expected-note side of the gameplay datapath. It steps through song memory at a fixed tempo and presents the current 5-lane note and its position. It opens a timed hit window per note and reports a per-note hit or miss from the match strobe returned by the equality checker. It feeds the scoring and display path.

## Interface
Parameters:
- TICKS_PER_STEP, 12_500_000: clk cycles per song step (≥4).
- WINDOW_TICKS, 3_125_000: cycles at the start of each step during which a match counts (1 ≤ WINDOW_TICKS < TICKS_PER_STEP).
- SONG_LEN, 128: number of steps (≤128).

Ports (one clock; reset `clear` is asynchronous, active-high):
- clk  in  1  system clock
- clear  in  1  async active-high reset
- start  in  1  begin playback from step 0 (level sampled each cycle)
- pause  in  1  freeze playback while high
- match  in  1  debounced buttons equal expected note (from equality checker)
- note  out  5  expected lane pattern for current step (0 = rest)
- song_pos  out  7  current step index
- window_open  out  1  hit window active for a non-rest note
- hit  out  1  one-cycle pulse: note judged hit
- miss  out  1  one-cycle pulse: note judged missed
- busy  out  1  playback in progress (PRIME, PLAY or PAUSED)
- done  out  1  song finished; held until restart or clear

## Operation
- States: IDLE, PRIME, PLAY, PAUSED, DONE.
- IDLE/DONE + start → PRIME; done clears on PRIME entry. start in any other state is ignored.
- PRIME lasts 2 cycles. Cycle 1 presents ROM address 0. Cycle 2 registers rom data into note, sets song_pos=0 and tick=0, then enters PLAY.
- PLAY: tick counts 0..TICKS_PER_STEP-1.
  - While tick < WINDOW_TICKS and note ≠ 0 and the note is not yet judged, window_open=1.
  - The first cycle with match=1 and window_open=1 sets judged and pulses hit on the next cycle.
  - At tick == WINDOW_TICKS with note ≠ 0 and not judged: pulse miss, set judged.
  - Rest steps (note == 0) never produce hit or miss.
  - At tick == TICKS_PER_STEP-1: song_pos increments, note loads the prefetched ROM word, and judged and tick clear.
  - At the last step (song_pos == SONG_LEN-1) end → DONE instead (see Configuration).
- The ROM address is always song_pos+1 during PLAY (prefetch), so the ROM word is ready at the step boundary.
- PLAY + pause → PAUSED: tick, song_pos and judged freeze, window_open=0, and match is ignored. pause low → PLAY, resuming at the frozen tick.
- clear at any time: all state and outputs return to reset values immediately.

## Timing
- Reset values: note=0, song_pos=0, window_open=0, hit=0, miss=0, busy=0, done=0, state IDLE.
- start sampled at cycle N → busy=1 at N+1. note and song_pos are valid and window_open=1 (non-rest) at N+3.
- hit/miss are registered, 1-cycle pulses: match at cycle M → hit at M+1. At most one of hit or miss fires per step, never both.
- match on the final window cycle (tick == WINDOW_TICKS-1) counts as a hit. match at tick == WINDOW_TICKS is ignored and miss fires.
- Step length is exactly TICKS_PER_STEP cycles when not paused. Paused cycles extend it one-for-one.
- done rises in the cycle after the last step's final tick. busy falls in that same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SONG_LOOP_EN defined: at the end of the last step, song_pos wraps to 0 and note loads ROM word 0 (prefetch address wraps to 0). Playback continues, DONE is never entered, and done stays 0.
- Not defined: end of the last step → DONE as above.

## Structure
- Shared package gh_pkg: state enum seq_state_t, NOTE_W=5, POS_W=7.
- One sub-module, song_rom: synchronous-read 128×5 ROM initialised from the song file. Interface is clk, addr[6:0] → data[4:0], with 1-cycle latency.
- Counter widths are derived with $clog2(TICKS_PER_STEP).

## Test plan
Bench parameters are TICKS_PER_STEP=8, WINDOW_TICKS=3, SONG_LEN=4, with ROM = {5'b00001, 5'b00000, 5'b10000, 5'b00110}.
- Start pulse → busy at +1, note=00001/song_pos=0 at +3, song_pos steps 0,1,2,3 every 8 cycles. done=1 and busy=0 exactly 32 cycles after PLAY entry.
- match on tick 2 of step 0 → hit pulse at tick 3. No miss in step 0. A second match in the same window → no extra pulse.
- No match in step 2 → miss pulse exactly once, in the cycle after tick 3. Step 1 (rest) → no hit, no miss.
- pause held 5 cycles mid-window of step 3 → window_open=0 while paused, match ignored, step lasts 13 cycles. A match after resume inside the window → hit.
- clear asserted mid-step 2 → all outputs at reset values asynchronously. A subsequent start replays from step 0.
- With SONG_LOOP_EN: after step 3, song_pos=0 and note=00001. done stays 0 over 3 full passes.
